// File: rtl/tap_tms_driver.sv
`default_nettype none
// ============================================================================
// Module   : tap_tms_driver
// Purpose  : JTAG TAP initiator. Drives TMS_Pad so that a downstream
//            IEEE 1149.1 TAP walks the shortest path to a requested stable
//            state, keeps a shadow copy of that TAP's state, and can hold in
//            the target for a programmable number of extra clocks.
// Ports    : GCLK_Pad   - clock (shared with the TAP, rising edge)
//            TRSTN_Pad  - asynchronous active-low reset
//            req_valid / req_ready / req_state / req_hold - navigation request
//            soft_rst   - force five TMS=1 clocks (Test-Logic-Reset)
//            TMS_Pad    - registered TMS to the TAP
//            cur_state  - shadow TAP state (IEEE encoding)
//            done / err - one-cycle completion / rejection pulses
//            obs_state  - observed TAP state (checker build only)
//            mismatch   - sticky shadow/TAP disagreement (checker build only)
// Config   : define TAP_DRV_CHECK_EN to enable the obs_state checker.
// Revision : 1.0 - initial release
// ============================================================================
module tap_tms_driver #(
  parameter int CNT_W = 8
) (
  input  logic             GCLK_Pad,
  input  logic             TRSTN_Pad,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_state,
  input  logic [CNT_W-1:0] req_hold,
  input  logic             soft_rst,
  output logic             TMS_Pad,
  output logic [3:0]       cur_state,
  output logic             done,
  output logic             err,
  input  logic [3:0]       obs_state,
  output logic             mismatch
);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_MOVE = 2'd1;
  localparam logic [1:0] c_ST_HOLD = 2'd2;
  localparam logic [1:0] c_ST_SRST = 2'd3;

  localparam logic [3:0] c_TLR = 4'hF;

  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
  // Five TMS=1 clocks: the counter is loaded with 4 and done fires at 0.
  localparam logic [CNT_W-1:0] c_SRST_CNT = CNT_W'(4);

  // IEEE 1149.1 TAP state transition.
  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic tms);
    logic [3:0] n;
    case (s)
      4'hF:    n = tms ? 4'hF : 4'hC;
      4'hC:    n = tms ? 4'h7 : 4'hC;
      4'h7:    n = tms ? 4'h4 : 4'h6;
      4'h6:    n = tms ? 4'h1 : 4'h2;
      4'h2:    n = tms ? 4'h1 : 4'h2;
      4'h1:    n = tms ? 4'h5 : 4'h3;
      4'h3:    n = tms ? 4'h0 : 4'h3;
      4'h0:    n = tms ? 4'h5 : 4'h2;
      4'h5:    n = tms ? 4'h7 : 4'hC;
      4'h4:    n = tms ? 4'hF : 4'hE;
      4'hE:    n = tms ? 4'h9 : 4'hA;
      4'hA:    n = tms ? 4'h9 : 4'hA;
      4'h9:    n = tms ? 4'hD : 4'hB;
      4'hB:    n = tms ? 4'h8 : 4'hB;
      4'h8:    n = tms ? 4'hD : 4'hA;
      default: n = tms ? 4'h7 : 4'hC; // 4'hD, Update-IR
    endcase
    return n;
  endfunction

  // Set of states reachable in at most one more step.
  function automatic logic [15:0] tap_expand(input logic [15:0] set);
    logic [15:0] r;
    r = set;
    for (int i = 0; i < 16; i++) begin
      if (set[i]) begin
        r[tap_next(4'(i), 1'b0)] = 1'b1;
        r[tap_next(4'(i), 1'b1)] = 1'b1;
      end
    end
    return r;
  endfunction

  // Shortest distance from s to t; no pair in the TAP graph is more than
  // seven steps apart, so eight frontier expansions are enough.
  function automatic logic [3:0] tap_dist(input logic [3:0] s, input logic [3:0] t);
    logic [15:0] reach;
    logic [3:0]  d;
    reach = 16'd1 << s;
    d     = 4'd15;
    for (int k = 0; k < 8; k++) begin
      if (reach[t] && (d == 4'd15)) d = 4'(k);
      reach = tap_expand(reach);
    end
    return d;
  endfunction

  function automatic logic is_stable(input logic [3:0] s);
    return (s == 4'hF) || (s == 4'hC) || (s == 4'h2) ||
           (s == 4'h3) || (s == 4'hA) || (s == 4'hB);
  endfunction

  logic [1:0]       r_state, w_state_nxt;
  logic             r_tms, w_tms_nxt;
  logic [3:0]       r_cur, w_cur_nxt;
  logic [3:0]       r_target, w_target_nxt;
  logic [CNT_W-1:0] r_hold, w_hold_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_done, w_done_nxt;
  logic             r_err, w_err_nxt;
  logic             r_ready;

  logic             w_srst_acc, w_req_acc;
  logic [3:0]       w_adv;
  logic [3:0]       w_src, w_dst;
  logic [3:0]       w_d0, w_d1;
  logic             w_path_bit;

  // r_ready is only ever high in IDLE, so it doubles as the idle qualifier.
  assign w_srst_acc = r_ready && soft_rst;
  assign w_req_acc  = r_ready && req_valid && !soft_rst;

  // What the TAP moves to on the coming edge, given the TMS it is sampling.
  assign w_adv = tap_next(r_cur, r_tms);

  // The next path bit is planned from the state the TAP will be in when it
  // samples that bit: current shadow when leaving IDLE, advanced shadow in MOVE.
  assign w_src = (r_state == c_ST_MOVE) ? w_adv    : r_cur;
  assign w_dst = (r_state == c_ST_MOVE) ? r_target : req_state;
  assign w_d0  = tap_dist(tap_next(w_src, 1'b0), w_dst);
  assign w_d1  = tap_dist(tap_next(w_src, 1'b1), w_dst);
  // Ties resolve to TMS=0.
  assign w_path_bit = (w_d1 < w_d0);

  // State register
  always_ff @(posedge GCLK_Pad or negedge TRSTN_Pad) begin
    if (!TRSTN_Pad) r_state <= c_ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (w_srst_acc) begin
          w_state_nxt = c_ST_SRST;
        end else if (w_req_acc && is_stable(req_state)) begin
          w_state_nxt = (req_state == r_cur) ? c_ST_HOLD : c_ST_MOVE;
        end
      end
      c_ST_MOVE: if (w_adv == r_target) w_state_nxt = c_ST_HOLD;
      c_ST_HOLD: if (r_cnt == '0)       w_state_nxt = c_ST_IDLE;
      default:   if (r_cnt == '0)       w_state_nxt = c_ST_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_tms_nxt    = r_tms;
    w_cur_nxt    = r_cur;
    w_target_nxt = r_target;
    w_hold_nxt   = r_hold;
    w_cnt_nxt    = r_cnt;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;

    if (r_state != c_ST_IDLE) w_cur_nxt = w_adv;

    case (r_state)
      c_ST_IDLE: begin
        // Parked: TMS=1 keeps TLR, TMS=0 keeps every other stable state.
        w_tms_nxt = (r_cur == c_TLR);
        if (w_srst_acc) begin
          w_tms_nxt = 1'b1;
          w_cnt_nxt = c_SRST_CNT;
        end else if (w_req_acc) begin
          w_target_nxt = req_state;
          w_hold_nxt   = req_hold;
          if (!is_stable(req_state)) begin
            w_err_nxt = 1'b1;
          end else if (req_state == r_cur) begin
            w_cnt_nxt = req_hold;
            w_tms_nxt = (req_state == c_TLR);
          end else begin
            w_tms_nxt = w_path_bit;
          end
        end
      end
      c_ST_MOVE: begin
        if (w_adv == r_target) begin
          w_cnt_nxt = r_hold;
          w_tms_nxt = (r_target == c_TLR);
        end else begin
          w_tms_nxt = w_path_bit;
        end
      end
      c_ST_HOLD: begin
        if (r_cnt == '0) w_done_nxt = 1'b1;
        else             w_cnt_nxt  = r_cnt - c_CNT_ONE;
      end
      default: begin
        w_tms_nxt = 1'b1;
        if (r_cnt == '0) begin
          w_cur_nxt  = c_TLR;
          w_done_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end
    endcase
  end

  always_ff @(posedge GCLK_Pad or negedge TRSTN_Pad) begin
    if (!TRSTN_Pad) begin
      r_tms    <= 1'b1;
      r_cur    <= c_TLR;
      r_target <= c_TLR;
      r_hold   <= '0;
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_ready  <= 1'b0;
    end else begin
      r_tms    <= w_tms_nxt;
      r_cur    <= w_cur_nxt;
      r_target <= w_target_nxt;
      r_hold   <= w_hold_nxt;
      r_cnt    <= w_cnt_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
      r_ready  <= (w_state_nxt == c_ST_IDLE);
    end
  end

  assign TMS_Pad   = r_tms;
  assign cur_state = r_cur;
  assign done      = r_done;
  assign err       = r_err;
  assign req_ready = r_ready;

`ifdef TAP_DRV_CHECK_EN
  // The observed TAP state trails the shadow by one clock.
  logic [3:0] r_cur_d;
  logic       r_mismatch;

  always_ff @(posedge GCLK_Pad or negedge TRSTN_Pad) begin
    if (!TRSTN_Pad) begin
      r_cur_d    <= c_TLR;
      r_mismatch <= 1'b0;
    end else begin
      r_cur_d <= r_cur;
      if (obs_state != r_cur_d) r_mismatch <= 1'b1;
    end
  end

  assign mismatch = r_mismatch;
`else
  logic w_unused_obs;
  assign w_unused_obs = ^obs_state;
  assign mismatch     = 1'b0;
`endif

endmodule
`default_nettype wire
